// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive front end: receiver state encoding
// and the oversampling / frame-shape constants used by the bit timing logic.
// -----------------------------------------------------------------------------
package uart_pkg;

  // Ticks per bit (16x oversampling) and the tick at which the start bit is
  // checked (middle of the bit). Data bits per frame (8N1).
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

  // Widths of the tick sub-counter (0..15) and the bit index (0..7).
  localparam int TICK_W = 4;
  localparam int BIT_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running prescaler producing one 1/16-bit tick every BAUD_DIV cycles.
// A synchronous clear restarts the count so tick phase can be aligned to an
// external event (the detected start edge).
//
// Ports:
//   clkin  in   system clock
//   rst_n  in   synchronous active-low reset
//   clr    in   synchronous clear of the prescaler (count <= 0)
//   tick   out  high for one cycle while the count sits at BAUD_DIV-1
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 27,
  parameter int unsigned DIV_W    = 16
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(BAUD_DIV - 1);

  logic [DIV_W-1:0] count;

  always_ff @(posedge clkin) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule : uart_baud_tick

// File: rtl/uart_rx_frontend.sv
// -----------------------------------------------------------------------------
// uart_rx_frontend
// 8N1 UART receiver with 16x oversampling. The asynchronous rx line is
// synchronised by two flops, start bits are qualified at mid-bit, data is
// sampled LSB first at the centre of each bit, and each completed byte lands
// in a single holding register guarded by a valid/ack handshake. Sticky
// framing and overrun flags report lost or malformed frames.
//
// Ports:
//   clkin      in   system clock
//   rst_n      in   synchronous active-low reset
//   rx         in   asynchronous serial input, idle high
//   rx_data    out  received byte, meaningful while rx_valid=1
//   rx_valid   out  holding register full
//   rx_ack     in   one-cycle pulse: consumer has taken rx_data
//   frame_err  out  sticky: stop bit sampled low
//   overrun    out  sticky: byte completed while holding register full
//   err_clr    in   clears frame_err and overrun
//   busy       out  receiver is inside a frame (not IDLE)
// -----------------------------------------------------------------------------
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 27,
  parameter int unsigned DIV_W    = 16
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 busy
);

  // ---------------------------------------------------------------------------
  // Input synchroniser. Both flops reset to the idle (high) line level so a
  // reset never looks like a start edge.
  // ---------------------------------------------------------------------------
  logic sync_1;
  logic rx_s;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two-flop chain into one.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= rx;
      rx_s   <= sync_1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick prescaler, restarted when a start edge is seen so the mid-bit sample
  // points are measured from the edge rather than from a free-running phase.
  // ---------------------------------------------------------------------------
  logic presc_clr;
  logic tick;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV),
    .DIV_W    (DIV_W)
  ) u_baud_tick (
    .clkin (clkin),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .tick  (tick)
  );

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  rx_state_t            state, state_next;
  logic [TICK_W-1:0]    tick_cnt, tick_cnt_next;
  logic [BIT_W-1:0]     bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 byte_done;
  logic                 frame_evt;

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default before the case so
    // that no path leaves a signal unassigned, which would infer a latch.
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    presc_clr     = 1'b0;
    byte_done     = 1'b0;
    frame_evt     = 1'b0;

    unique case (state)
      IDLE: begin
        // A low synchronised line is a candidate start bit. Ticks arriving
        // while idle are meaningless, the prescaler is restarted here.
        if (!rx_s) begin
          state_next    = START;
          tick_cnt_next = '0;
          presc_clr     = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          if (tick_cnt == TICK_W'(MID_SAMPLE - 1)) begin
            // Mid start bit: a high line means the low pulse was a glitch.
            tick_cnt_next = '0;
            bit_idx_next  = '0;
            state_next    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
            tick_cnt_next = '0;
            // LSB arrives first, so shift in from the top; after eight
            // samples the first bit has reached bit 0.
            shift_next    = {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
              state_next = STOP;
            end else begin
              bit_idx_next = bit_idx + BIT_W'(1);
            end
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
            tick_cnt_next = '0;
            state_next    = IDLE;
            byte_done     = rx_s;
            frame_evt     = !rx_s;
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Holding register and sticky error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // The clear is written first so that an error event in the same cycle
      // overrides it (last assignment wins) and the flag stays set.
      if (err_clr) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end

      if (frame_evt) begin
        frame_err <= 1'b1;
      end

      if (byte_done) begin
        // An ack in the completing cycle frees the register just in time,
        // so the new byte is loaded and rx_valid simply stays high.
        if (!rx_valid || rx_ack) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule : uart_rx_frontend

// File: tb/tb_uart_rx_frontend.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frontend
// Self-checking bench for uart_rx_frontend at BAUD_DIV=4 (64 cycles per bit).
// Expected bytes are queued when a frame is driven; a monitor captures each
// rising edge of rx_valid together with its cycle number, and each scenario
// task pops and compares them against its own expectations.
// -----------------------------------------------------------------------------
module tb_uart_rx_frontend;

  localparam int BAUD_DIV  = 4;
  localparam int BIT_CYC   = 16 * BAUD_DIV;
  localparam int FRAME_CYC = 10 * BIT_CYC;
  // Cycles from driving the start edge to the first cycle rx_valid is seen
  // high: 2 sync + 1 idle decision + (8 + 9*16) ticks * 4 - 1 + 1 load.
  localparam int LOAD_LAT  = 611;

  logic       clkin    = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx       = 1'b1;
  logic       err_clr  = 1'b0;
  logic       ack_man  = 1'b0;
  logic       ack_auto = 1'b0;
  logic       auto_ack = 1'b0;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  assign rx_ack = ack_man | ack_auto;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int start_cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  logic       prev_valid = 1'b0;

  uart_rx_frontend #(
    .BAUD_DIV (BAUD_DIV),
    .DIV_W    (16)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  // Monitor: record every new byte presentation; optionally ack it at once.
  always @(negedge clkin) begin
    prev_valid <= rx_valid;
    if (rx_valid && !prev_valid) begin
      got_q.push_back(rx_data);
      got_cyc_q.push_back(cyc);
    end
    ack_auto <= auto_ack && rx_valid && !ack_auto;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drives ncyc cycles of an 8N1 frame starting at a negedge. ack_at/rst_at
  // select a cycle index at which rx_ack is pulsed or rst_n pulled low.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int ack_at, input int rst_at, input int ncyc);
    int k;
    for (int i = 0; i < ncyc; i++) begin
      if (i == 0) start_cyc = cyc;
      if (i < BIT_CYC) begin
        rx = 1'b0;
      end else if (i < 9 * BIT_CYC) begin
        k  = i / BIT_CYC - 1;
        rx = b[k[2:0]];
      end else begin
        rx = stop;
      end
      ack_man = (i == ack_at);
      rst_n   = (i != rst_at);
      @(negedge clkin);
    end
    rx      = 1'b1;
    ack_man = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic pulse_ack();
    ack_man = 1'b1;
    @(negedge clkin);
    ack_man = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clkin);
    err_clr = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clkin);
      k++;
    end
    checks++;
    if (got_q.size() < n) begin
      failures++;
      $display("FAIL %s_timeout got=%0d bytes required=%0d", tag, got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(3);
    checks++;
    if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=000",
               {rx_data, rx_valid, frame_err, overrun, busy});
    end
    rst_n = 1'b1;
    idle(20);
    checks++;
    if ({rx_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle valid_busy got=%b required=00", {rx_valid, busy});
    end
  endtask

  task automatic test_basic();
    logic [7:0] g, e;
    int gc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, -1, FRAME_CYC);
    wait_got(1, 200, "basic");
    if (got_q.size() > 0) begin
      g  = got_q.pop_front();
      gc = got_cyc_q.pop_front();
      e  = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL basic_data got=%h required=%h", g, e);
      end
      checks++;
      if (gc - start_cyc != LOAD_LAT) begin
        failures++;
        $display("FAIL basic_latency got=%0d required=%0d", gc - start_cyc, LOAD_LAT);
      end
    end
    checks++;
    if ({rx_valid, frame_err, overrun, busy} !== 4'b1000) begin
      failures++;
      $display("FAIL basic_status got=%b required=1000",
               {rx_valid, frame_err, overrun, busy});
    end
    pulse_ack();
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_ack_clears got=%b required=0", rx_valid);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] g, e;
    // Short glitch: starts a frame, rejected at the mid start bit.
    rx = 1'b0;
    idle(10);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch20_busy got=%b required=1", busy);
    end
    idle(10);
    rx = 1'b1;
    idle(60);
    checks++;
    if ({busy, rx_valid, frame_err} !== 3'b000 || got_q.size() != 0) begin
      failures++;
      $display("FAIL glitch20_reject busy_valid_ferr=%b bytes=%0d required=000/0",
               {busy, rx_valid, frame_err}, got_q.size());
    end
    // Almost a full bit low: accepted as a start bit, line then reads 0xFF.
    exp_q.push_back(8'hFF);
    rx = 1'b0;
    idle(BIT_CYC - 1);
    rx = 1'b1;
    wait_got(1, 800, "glitch63");
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      void'(got_cyc_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL glitch63_data got=%h required=%h", g, e);
      end
    end
    checks++;
    if ({frame_err, overrun} !== 2'b00) begin
      failures++;
      $display("FAIL glitch63_flags got=%b required=00", {frame_err, overrun});
    end
    pulse_ack();
    idle(80);
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, -1, -1, FRAME_CYC);
    idle(100);
    checks++;
    if ({frame_err, rx_valid, overrun, busy} !== 4'b1000 || got_q.size() != 0) begin
      failures++;
      $display("FAIL frame_err_set ferr_valid_ovr_busy=%b bytes=%0d required=1000/0",
               {frame_err, rx_valid, overrun, busy}, got_q.size());
    end
    pulse_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL frame_err_clear got=%b required=0", frame_err);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] g, e;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1, FRAME_CYC);
    send_frame(8'h22, 1'b1, -1, -1, FRAME_CYC);
    idle(40);
    wait_got(1, 10, "overrun");
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      void'(got_cyc_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL overrun_first got=%h required=%h", g, e);
      end
    end
    checks++;
    if (rx_data !== 8'h11 || {rx_valid, overrun, frame_err} !== 3'b110 || got_q.size() != 0) begin
      failures++;
      $display("FAIL overrun_state data=%h valid_ovr_ferr=%b bytes=%0d required=11/110/0",
               rx_data, {rx_valid, overrun, frame_err}, got_q.size());
    end
    pulse_ack();
    pulse_clr();
    checks++;
    if ({rx_valid, overrun} !== 2'b00) begin
      failures++;
      $display("FAIL overrun_cleared got=%b required=00", {rx_valid, overrun});
    end
    // Same pair, with the ack landing on the exact load cycle of the second.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1, FRAME_CYC);
    wait_got(1, 10, "ackload_first");
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      void'(got_cyc_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL ackload_first got=%h required=%h", g, e);
      end
    end
    send_frame(8'h22, 1'b1, LOAD_LAT - 1, -1, FRAME_CYC);
    idle(40);
    checks++;
    if (rx_data !== 8'h22 || {rx_valid, overrun} !== 2'b10 || got_q.size() != 0) begin
      failures++;
      $display("FAIL ackload_second data=%h valid_ovr=%b bytes=%0d required=22/10/0",
               rx_data, {rx_valid, overrun}, got_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] g, e;
    // Holding register is full (0x22) on entry; reset must clear it.
    send_frame(8'h5A, 1'b1, -1, 5 * BIT_CYC + 32, 5 * BIT_CYC + 33);
    checks++;
    if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
      failures++;
      $display("FAIL midreset_outputs got=%h required=000",
               {rx_data, rx_valid, frame_err, overrun, busy});
    end
    idle(FRAME_CYC);
    checks++;
    if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || got_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_quiet got=%b bytes=%0d required=0000/0",
               {rx_valid, frame_err, overrun, busy}, got_q.size());
    end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, -1, FRAME_CYC);
    wait_got(1, 200, "midreset_clean");
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      void'(got_cyc_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL midreset_clean got=%h required=%h", g, e);
      end
    end
    pulse_ack();
    idle(20);
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [3];
    logic [7:0] g, e;
    pat = '{8'h00, 8'hFF, 8'h81};
    auto_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pat[i]);
      send_frame(pat[i], 1'b1, -1, -1, FRAME_CYC);
    end
    wait_got(3, 200, "b2b");
    idle(10);
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front();
        void'(got_cyc_q.pop_front());
        e = exp_q.pop_front();
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL b2b_byte%0d got=%h required=%h", i, g, e);
        end
      end
    end
    checks++;
    if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || got_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_final got=%b extra_bytes=%0d required=0000/0",
               {rx_valid, frame_err, overrun, busy}, got_q.size());
    end
    auto_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx_frontend
